irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Parametrised interrupt controller that replaces the single raw `interrupt` line driven into the pipelined RISC-V core (`main`).
- Collects NUM_IRQ request lines and latches pending requests.
- Applies a software-writable mask and priority-encodes the lowest-index unmasked pending request.
- Presents one request with a vector id to the core and tracks a REQ/ack/EOI handshake, with no nesting.

Parameters:
- NUM_IRQ, 8, number of interrupt request channels (1..32).
- ID_W, 3, width of the vector id; 2^ID_W >= NUM_IRQ is required.
- EDGE_MODE, {NUM_IRQ{1'b1}}, per-channel mode: bit=1 is rising-edge triggered, bit=0 is level triggered.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- irq_in  input  NUM_IRQ  raw request lines, already synchronous to clk.
- mask_we  input  1  write strobe for the mask register.
- mask_wdata  input  NUM_IRQ  new mask value; bit=1 means the channel is masked.
- mask_q  output  NUM_IRQ  current mask register.
- pending_q  output  NUM_IRQ  current pending register.
- interrupt  output  1  request to the core (connects to the core's interrupt input).
- irq_id  output  ID_W  index of the channel being requested or serviced.
- ack  input  1  core accepts the request (1-cycle pulse).
- eoi  input  1  core finished the ISR (1-cycle pulse).
- busy  output  1  high in REQ or SERVICE.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, mask_q=all ones, pending_q=0, irq_d=0.
  - interrupt=0, irq_id=0, busy=0.
  - Reset mid-handshake drops any request in flight; no ack/eoi is needed afterwards.
- irq_d register: holds irq_in from the previous cycle.
- Pending set term per channel:
  - Edge mode: set = irq_in & ~irq_d.
  - Level mode: set = irq_in.
- Pending update: pending_q <= (pending_q & ~clr) | set.
  - clr is one-hot of irq_id, asserted only on an accepted ack.
  - Set wins over clear in the same cycle.
- Pending bits latch even when the channel is masked. Masking only blocks arbitration.
- Mask write: mask_we=1 loads mask_wdata into mask_q at the next edge. Arbitration uses mask_q, so the new mask affects selection from the following cycle.
- Arbitration:
  - eligible = pending_q & ~mask_q.
  - The winner is the lowest set index (index 0 is highest priority).
- IDLE:
  - If eligible != 0: next state REQ, interrupt<=1, irq_id<=winner.
  - Otherwise remain in IDLE.
- REQ:
  - interrupt=1 and irq_id are held stable. A new higher-priority arrival does not preempt, and a mask change does not withdraw the request.
  - On ack=1: next state SERVICE, interrupt<=0, clr pending bit irq_id.
  - A level channel whose irq_in is still high re-sets its pending bit in the same cycle (set wins).
- SERVICE:
  - interrupt=0; irq_id holds the serviced channel.
  - On eoi=1: next state IDLE. A new REQ can start at the earliest on the cycle after IDLE is entered.
- Ignored inputs:
  - ack in IDLE or SERVICE has no effect.
  - eoi in IDLE or REQ has no effect.
  - ack and eoi in the same cycle: only the one valid for the current state acts.
- Latency (edge channel, unmasked, controller IDLE):
  - irq_in rises before edge N.
  - pending_q bit is set after edge N.
  - interrupt=1 after edge N+1.
- busy = (state != IDLE).
- Width rules:
  - irq_id is the zero-extended channel index.
  - Channels >= NUM_IRQ do not exist; mask_wdata has no extra bits.

Test Plan:
- Reset: hold rst 2 cycles with irq_in=8'hFF -> mask_q=8'hFF, pending_q=0, interrupt=0, irq_id=0. Release rst -> pending_q=8'hFF (edges are not seen because irq_d was 0? no: irq_d=0 so edges are seen), and interrupt stays 0 because all channels are masked.
- Single edge: mask=8'h00, pulse irq_in[5] for 1 cycle at edge N -> pending_q=8'h20 after N, interrupt=1 with irq_id=5 after N+1. ack -> pending_q=0 and interrupt=0 next cycle. eoi -> busy=0.
- Priority and no preemption: pending bits 3 and 6 -> irq_id=3. During REQ, raise irq_in[1] -> irq_id stays 3. After ack+eoi -> next request irq_id=1, then 6.
- Mask: pending bit 2 set with mask_q[2]=1 -> interrupt stays 0 for 10 cycles. Write mask_wdata=8'h00 -> interrupt=1 with irq_id=2 two cycles after mask_we.
- Level re-assert: EDGE_MODE bit 4=0, hold irq_in[4]=1, ack -> pending_q[4] remains 1. After eoi -> interrupt reasserts with irq_id=4.
- Reset mid-op: assert rst while in SERVICE -> next cycle state=IDLE, busy=0, pending_q=0. A subsequent eoi is ignored.

Source files
------------

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller: pending latch, mask, fixed priority, REQ/ack/EOI handshake
module irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W = 3,
  parameter logic [NUM_IRQ-1:0] EDGE_MODE = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask_q,
  output logic [NUM_IRQ-1:0] pending_q,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  input  logic               ack,
  input  logic               eoi,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state, state_nx;
  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] set;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    irq_id_nx;
  logic               interrupt_nx;

  assign set      = (irq_in & ~irq_d & EDGE_MODE) | (irq_in & ~EDGE_MODE);
  assign eligible = pending_q & ~mask_q;
  assign busy     = (state != IDLE);

  // Scan downwards so the lowest set index is the last (and winning) assignment.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    state_nx     = state;
    interrupt_nx = interrupt;
    irq_id_nx    = irq_id;
    clr          = '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nx     = REQ;
          interrupt_nx = 1'b1;
          irq_id_nx    = winner;
        end
      end
      REQ: begin
        if (ack) begin
          state_nx     = SERVICE;
          interrupt_nx = 1'b0;
          for (int i = 0; i < NUM_IRQ; i++) clr[i] = (irq_id == ID_W'(i));
        end
      end
      SERVICE: begin
        if (eoi) state_nx = IDLE;
      end
      default: begin
        state_nx     = IDLE;
        interrupt_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask_q    <= '1;
      pending_q <= '0;
      irq_d     <= '0;
      interrupt <= 1'b0;
      irq_id    <= '0;
    end else begin
      state     <= state_nx;
      interrupt <= interrupt_nx;
      irq_id    <= irq_id_nx;
      irq_d     <= irq_in;
      // Set is OR'ed in after the clear so a still-active request re-latches.
      pending_q <= (pending_q & ~clr) | set;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

endmodule
